// File: rtl/adjust_pkg.sv
// rtl/adjust_pkg.sv - shared state type and default timing for the time-adjust front end
package adjust_pkg;

    typedef enum logic {ST_RUN, ST_EDIT} state_t;

    localparam int DEF_N_DIGITS         = 6;
    localparam int DEF_DEBOUNCE_CYC     = 250000;
    localparam int DEF_REPEAT_DELAY_CYC = 12500000;
    localparam int DEF_REPEAT_RATE_CYC  = 2500000;
    localparam int DEF_TIMEOUT_SEC      = 30;

endpackage

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - 2-FF sync, hold-count debounce and optional auto-repeat press pulse
module button_conditioner
    import adjust_pkg::*;
#(
    parameter int DEBOUNCE_CYC     = DEF_DEBOUNCE_CYC,
    parameter bit REPEAT_EN        = 1'b0,
    parameter int REPEAT_DELAY_CYC = DEF_REPEAT_DELAY_CYC,
    parameter int REPEAT_RATE_CYC  = DEF_REPEAT_RATE_CYC
) (
    input  logic CLK,
    input  logic RST,
    input  logic btn,
    output logic press
);

    localparam int CNT_MAX = REPEAT_EN ? DEBOUNCE_CYC + REPEAT_DELAY_CYC : DEBOUNCE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RATE_W  = $clog2(REPEAT_RATE_CYC + 1);

    localparam logic [CNT_W-1:0]  CNT_TOP  = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0]  CNT_DEB  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_REP  = CNT_W'(CNT_MAX - 1);
    localparam logic [RATE_W-1:0] RATE_TOP = RATE_W'(REPEAT_RATE_CYC - 1);

    logic              sync1;
    logic              sync2;
    logic [CNT_W-1:0]  cnt;
    logic [RATE_W-1:0] rate_cnt;
    logic              saturated;
    logic              hit;

    assign saturated = (cnt == CNT_TOP);

    // Hold count saturates at the first-repeat point; the rate counter then paces later repeats.
    always_comb begin
        hit = 1'b0;
        if (sync2) begin
            hit = (cnt == CNT_DEB);
            if (REPEAT_EN && ((cnt == CNT_REP) || (saturated && rate_cnt == RATE_TOP)))
                hit = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            cnt      <= '0;
            rate_cnt <= '0;
            press    <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= hit;
            if (!sync2) begin
                cnt      <= '0;
                rate_cnt <= '0;
            end else if (!saturated) begin
                cnt <= cnt + 1'b1;
            end else if (REPEAT_EN) begin
                rate_cnt <= (rate_cnt == RATE_TOP) ? '0 : rate_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/adjust_ctrl.sv
// rtl/adjust_ctrl.sv - RUN/EDIT mode FSM, one-hot digit selector and idle timeout for time adjust
module adjust_ctrl
    import adjust_pkg::*;
#(
    parameter int N_DIGITS         = DEF_N_DIGITS,
    parameter int DEBOUNCE_CYC     = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY_CYC = DEF_REPEAT_DELAY_CYC,
    parameter int REPEAT_RATE_CYC  = DEF_REPEAT_RATE_CYC,
    parameter int TIMEOUT_SEC      = DEF_TIMEOUT_SEC
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                BtnMode,
    input  logic                BtnDigit,
    input  logic                BtnInc,
    input  logic                BtnDec,
    input  logic                Tick1Hz,
    output logic                Editing,
    output logic [N_DIGITS-1:0] Digit,
    output logic                IncPulse,
    output logic                DecPulse,
    output logic                Commit,
    output logic                Cancel
);

    localparam int                IDLE_W    = $clog2(TIMEOUT_SEC + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_SEC - 1);

    logic mode_p;
    logic digit_p;
    logic inc_p;
    logic dec_p;
    logic any_p;
    logic timeout;

    state_t              state;
    state_t              state_d;
    logic [N_DIGITS-1:0] digit_q;
    logic [N_DIGITS-1:0] digit_d;
    logic [IDLE_W-1:0]   idle_q;
    logic [IDLE_W-1:0]   idle_d;
    logic                inc_d;
    logic                dec_d;
    logic                commit_d;
    logic                cancel_d;

    button_conditioner #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_EN(1'b0),
        .REPEAT_DELAY_CYC(REPEAT_DELAY_CYC), .REPEAT_RATE_CYC(REPEAT_RATE_CYC)
    ) u_mode (.CLK(CLK), .RST(RST), .btn(BtnMode), .press(mode_p));

    button_conditioner #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_EN(1'b0),
        .REPEAT_DELAY_CYC(REPEAT_DELAY_CYC), .REPEAT_RATE_CYC(REPEAT_RATE_CYC)
    ) u_digit (.CLK(CLK), .RST(RST), .btn(BtnDigit), .press(digit_p));

    button_conditioner #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_EN(1'b1),
        .REPEAT_DELAY_CYC(REPEAT_DELAY_CYC), .REPEAT_RATE_CYC(REPEAT_RATE_CYC)
    ) u_inc (.CLK(CLK), .RST(RST), .btn(BtnInc), .press(inc_p));

    button_conditioner #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_EN(1'b1),
        .REPEAT_DELAY_CYC(REPEAT_DELAY_CYC), .REPEAT_RATE_CYC(REPEAT_RATE_CYC)
    ) u_dec (.CLK(CLK), .RST(RST), .btn(BtnDec), .press(dec_p));

    assign any_p   = mode_p | digit_p | inc_p | dec_p;
    // Any button activity in the same cycle as a tick keeps the edit alive.
    assign timeout = Tick1Hz && !any_p && (idle_q == IDLE_LAST);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= ST_RUN;
            digit_q  <= N_DIGITS'(1);
            idle_q   <= '0;
            IncPulse <= 1'b0;
            DecPulse <= 1'b0;
            Commit   <= 1'b0;
            Cancel   <= 1'b0;
        end else begin
            state    <= state_d;
            digit_q  <= digit_d;
            idle_q   <= idle_d;
            IncPulse <= inc_d;
            DecPulse <= dec_d;
            Commit   <= commit_d;
            Cancel   <= cancel_d;
        end
    end

    always_comb begin
        state_d = state;
        if (state == ST_RUN) begin
            if (mode_p)
                state_d = ST_EDIT;
        end else begin
            if (mode_p || timeout)
                state_d = ST_RUN;
        end
    end

    always_comb begin
        digit_d  = digit_q;
        idle_d   = idle_q;
        inc_d    = 1'b0;
        dec_d    = 1'b0;
        commit_d = 1'b0;
        cancel_d = 1'b0;
        if (state == ST_RUN) begin
            if (mode_p) begin
                digit_d = N_DIGITS'(1);
                idle_d  = '0;
            end
        end else begin
            // Mode wins over both timeout and digit advance.
            if (mode_p)
                commit_d = 1'b1;
            else begin
                cancel_d = timeout;
                if (digit_p)
                    digit_d = {digit_q[N_DIGITS-2:0], digit_q[N_DIGITS-1]};
            end
            inc_d = inc_p & ~dec_p;
            dec_d = dec_p & ~inc_p;
            if (any_p)
                idle_d = '0;
            else if (Tick1Hz)
                idle_d = idle_q + 1'b1;
        end
    end

    assign Editing = (state == ST_EDIT);
    assign Digit   = digit_q;

endmodule

// File: tb/tb_adjust_ctrl.sv
// tb/tb_adjust_ctrl.sv - scoreboard bench for adjust_ctrl with small timing parameters
module tb_adjust_ctrl;

    localparam int ND   = 4;
    localparam int DEB  = 4;
    localparam int DLY  = 10;
    localparam int RATE = 3;
    localparam int TMO  = 3;

    localparam int B_MODE = 0, B_DIGIT = 1, B_INC = 2, B_DEC = 3;
    localparam int K_INC = 0, K_DEC = 1, K_COMMIT = 2, K_CANCEL = 3, K_NONE = -1;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          BtnMode = 1'b0, BtnDigit = 1'b0, BtnInc = 1'b0, BtnDec = 1'b0;
    logic          Tick1Hz = 1'b0;
    logic          Editing;
    logic [ND-1:0] Digit;
    logic          IncPulse, DecPulse, Commit, Cancel;

    adjust_ctrl #(
        .N_DIGITS(ND), .DEBOUNCE_CYC(DEB), .REPEAT_DELAY_CYC(DLY),
        .REPEAT_RATE_CYC(RATE), .TIMEOUT_SEC(TMO)
    ) dut (
        .CLK(CLK), .RST(RST), .BtnMode(BtnMode), .BtnDigit(BtnDigit),
        .BtnInc(BtnInc), .BtnDec(BtnDec), .Tick1Hz(Tick1Hz),
        .Editing(Editing), .Digit(Digit), .IncPulse(IncPulse),
        .DecPulse(DecPulse), .Commit(Commit), .Cancel(Cancel)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct { int kind; int at; } ev_t;
    ev_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;
    int inc_seen = 0;
    int dec_seen = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
    endtask

    // Output monitor: every pulse must match the next scoreboard entry in kind and cycle.
    logic [3:0] mon_o;
    ev_t        mon_e;
    always @(negedge CLK) begin
        if (RST) begin
            mon_o = {Cancel, Commit, DecPulse, IncPulse};
            for (int k = 0; k < 4; k++) begin
                if (mon_o[k]) begin
                    if (k == K_INC) inc_seen++;
                    if (k == K_DEC) dec_seen++;
                    if (sb.size() == 0) begin
                        check("unexpected_ev", int'(mon_o), 0);
                    end else begin
                        mon_e = sb.pop_front();
                        check("ev_kind", k, mon_e.kind);
                        check("ev_cyc", cyc, mon_e.at);
                    end
                end
            end
        end
    end

    task automatic set_btn(input int b, input logic v);
        case (b)
            B_MODE:  BtnMode  = v;
            B_DIGIT: BtnDigit = v;
            B_INC:   BtnInc   = v;
            default: BtnDec   = v;
        endcase
    endtask

    // Called at a negedge; pushes the pulses the hold should produce, then releases and settles.
    task automatic press(input int b, input int hold, input int kind);
        int c0;
        c0 = cyc;
        set_btn(b, 1'b1);
        if (kind != K_NONE) begin
            for (int n = 1; n <= hold; n++) begin
                if (n == DEB ||
                    ((kind == K_INC || kind == K_DEC) && n >= DEB + DLY && (n - DEB - DLY) % RATE == 0))
                    sb.push_back('{kind, c0 + 3 + n});
            end
        end
        repeat (hold) @(negedge CLK);
        set_btn(b, 1'b0);
        repeat (4) @(negedge CLK);
    endtask

    task automatic tick(input bit exp_cancel);
        Tick1Hz = 1'b1;
        if (exp_cancel) sb.push_back('{K_CANCEL, cyc + 1});
        @(negedge CLK);
        Tick1Hz = 1'b0;
        @(negedge CLK);
    endtask

    int c0;
    int inc0;
    int dec0;

    initial begin
        repeat (3) @(negedge CLK);
        check("rst_editing", Editing, 0);
        check("rst_digit", Digit, 1);
        check("rst_pulses", {IncPulse, DecPulse, Commit, Cancel}, 0);
        RST = 1'b1;
        @(negedge CLK);

        // 1: glitchy mode press enters EDIT exactly once
        BtnMode = 1'b1;
        repeat (3) @(negedge CLK);
        BtnMode = 1'b0;
        @(negedge CLK);
        check("glitch_no_edit", Editing, 0);
        press(B_MODE, 6, K_NONE);
        check("t1_editing", Editing, 1);
        check("t1_digit", Digit, 1);

        // 2: digit walk with wrap
        press(B_DIGIT, 6, K_NONE); check("t2_d1", Digit, 4'b0010);
        press(B_DIGIT, 6, K_NONE); check("t2_d2", Digit, 4'b0100);
        press(B_DIGIT, 6, K_NONE); check("t2_d3", Digit, 4'b1000);
        press(B_DIGIT, 6, K_NONE); check("t2_d4", Digit, 4'b0001);

        // 3: held increment auto-repeats, then a single decrement
        inc0 = inc_seen;
        press(B_INC, 30, K_INC);
        repeat (5) @(negedge CLK);
        check("t3_inc_count", inc_seen - inc0, 7);
        dec0 = dec_seen;
        press(B_DEC, 5, K_DEC);
        check("t3_dec_count", dec_seen - dec0, 1);

        // 4: idle timeout, restarted by an inc press
        tick(1'b0);
        tick(1'b0);
        press(B_INC, 4, K_INC);
        tick(1'b0);
        check("t4_still_edit", Editing, 1);
        tick(1'b0);
        tick(1'b1);
        check("t4_cancel_exit", Editing, 0);

        // 5: mode press coincident with the third idle tick commits
        press(B_MODE, 6, K_NONE);
        check("t5_edit", Editing, 1);
        tick(1'b0);
        tick(1'b0);
        c0 = cyc;
        BtnMode = 1'b1;
        sb.push_back('{K_COMMIT, c0 + 3 + DEB});
        repeat (DEB + 2) @(negedge CLK);
        Tick1Hz = 1'b1;
        @(negedge CLK);
        Tick1Hz = 1'b0;
        @(negedge CLK);
        BtnMode = 1'b0;
        repeat (4) @(negedge CLK);
        check("t5_commit_exit", Editing, 0);

        press(B_MODE, 6, K_NONE);
        inc0 = inc_seen;
        dec0 = dec_seen;
        BtnInc = 1'b1;
        BtnDec = 1'b1;
        repeat (6) @(negedge CLK);
        BtnInc = 1'b0;
        BtnDec = 1'b0;
        repeat (4) @(negedge CLK);
        check("t5_both_inc", inc_seen - inc0, 0);
        check("t5_both_dec", dec_seen - dec0, 0);
        press(B_DIGIT, 6, K_NONE);
        press(B_MODE, 6, K_COMMIT);
        check("t5_digit_kept", Digit, 4'b0010);

        // 6: reset mid-edit with inc held
        press(B_MODE, 6, K_NONE);
        check("t6_entry_digit", Digit, 1);
        press(B_DIGIT, 6, K_NONE);
        inc0 = inc_seen;
        BtnInc = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        check("t6_rst_editing", Editing, 0);
        check("t6_rst_digit", Digit, 1);
        RST = 1'b1;
        repeat (25) @(negedge CLK);
        check("t6_run_no_inc", inc_seen - inc0, 0);
        check("t6_still_run", Editing, 0);
        BtnInc = 1'b0;
        repeat (6) @(negedge CLK);

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
